mem_bus_ctrl: RTL

- Memory/IO bus controller between the multi-cycle CPU datapath and the off-chip single-port SRAM plus the serial port.
- Serves every memory access from the datapath: instruction fetch (IFetch) and LW/SW data accesses (Mem stage).
- Converts a single-cycle-sampled request into timed SRAM strobes with wait states, or into a UART handshake for memory-mapped IO, and returns a one-cycle ack.
- Only one transaction is in flight at a time; the controller does no arbitration.

---
 rtl/mem_bus_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory/IO bus controller: turns a held CPU request into timed SRAM strobes
// with wait states, or a UART handshake for the two memory-mapped registers.
module mem_bus_ctrl #(
  parameter int          WAIT_CYCLES    = 2,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_dq_o,
  input  logic [15:0] ram_dq_i,
  output logic        ram_dq_t,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ack
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          lat_we_q, lat_we_d;
  logic [15:0]   lat_addr_q, lat_addr_d;
  logic [15:0]   lat_wdata_q, lat_wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   ram_addr_q, ram_addr_d;
  logic [15:0]   ram_dq_o_q, ram_dq_o_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          rx_ack_q, rx_ack_d;
  logic          ack_q, busy_q, dq_t_q, ce_n_q, oe_n_q, we_n_q, tx_valid_q;
  logic          ack_d, busy_d, dq_t_d, ce_n_d, oe_n_d, we_n_d, tx_valid_d;

  // Next-state logic; a request is latched first and decoded one cycle later
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_dq_o_d  = ram_dq_o_q;
    tx_data_d   = tx_data_q;
    rx_ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          cnt_d  = '0;
          if (lat_addr_q == UART_STAT_ADDR) begin
            if (!lat_we_q) begin
              rdata_d = {14'd0, uart_rx_valid, uart_tx_ready};
            end else begin
              rdata_d = rdata_q;
            end
            state_d = S_ACK;
          end else if (lat_addr_q == UART_DATA_ADDR) begin
            if (lat_we_q) begin
              tx_data_d = lat_wdata_q[7:0];
              state_d   = S_TX;
            end else if (uart_rx_valid) begin
              rdata_d  = {8'd0, uart_rx_data};
              rx_ack_d = 1'b1;
              state_d  = S_ACK;
            end else begin
              rdata_d = 16'd0;
              state_d = S_ACK;
            end
          end else if (lat_we_q) begin
            ram_addr_d = lat_addr_q;
            ram_dq_o_d = lat_wdata_q;
            state_d    = S_WR_SETUP;
          end else begin
            ram_addr_d = lat_addr_q;
            state_d    = S_RD;
          end
        end else if (req) begin
          pend_d      = 1'b1;
          lat_we_d    = we;
          lat_addr_d  = addr;
          lat_wdata_d = wdata;
        end else begin
          pend_d = 1'b0;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = ram_dq_i;
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_HOLD: state_d = S_ACK;
      S_TX: begin
        if (uart_tx_ready) begin
          state_d = S_ACK;
        end else begin
          state_d = S_TX;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register
  always_comb begin
    ce_n_d     = !((state_d == S_RD) || (state_d == S_WR_SETUP) ||
                   (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD));
    oe_n_d     = (state_d != S_RD);
    we_n_d     = (state_d != S_WR_PULSE);
    dq_t_d     = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                 (state_d == S_WR_HOLD);
    tx_valid_d = (state_d == S_TX);
    ack_d      = (state_d == S_ACK);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 16'd0;
      lat_wdata_q <= 16'd0;
      rdata_q     <= 16'd0;
      ram_addr_q  <= 16'd0;
      ram_dq_o_q  <= 16'd0;
      tx_data_q   <= 8'd0;
      rx_ack_q    <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      dq_t_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_dq_o_q  <= ram_dq_o_d;
      tx_data_q   <= tx_data_d;
      rx_ack_q    <= rx_ack_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      dq_t_q      <= dq_t_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign rdata         = rdata_q;
  assign ack           = ack_q;
  assign busy          = busy_q;
  assign ram_addr      = ram_addr_q;
  assign ram_dq_o      = ram_dq_o_q;
  assign ram_dq_t      = dq_t_q;
  assign ram_ce_n      = ce_n_q;
  assign ram_oe_n      = oe_n_q;
  assign ram_we_n      = we_n_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_rx_ack   = rx_ack_q;

endmodule
